// File: rtl/tap_delay_line.sv
// Purpose : DEPTH-stage tapped delay line with per-stage valid bits, stall, flush,
//           fill counter and one registered, run-time selectable tap.
// Latency : din reaches tap k after k+1 enabled edges; dout lags the taps by one edge.
// Backpr. : none; en=0 stalls the whole chain, while the output mux keeps tracking sel.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous flush (highest priority)
//   en         shift enable; 0 holds stages, valids and fill
//   din_valid  qualifies din; an invalid word still shifts in, with its valid bit cleared
//   din        word entering stage 0
//   sel        tap index for dout (0 = newest)
//   taps       flat bus of all stages, stage k at [k*DATA_WIDTH +: DATA_WIDTH]
//   tap_valid  bit k set when stage k holds valid data
//   dout       registered copy of stage[sel]
//   dout_valid registered valid of stage[sel]
//   sel_err    registered, set when the sampled sel >= DEPTH
//   fill       number of valid stages, 0..DEPTH
//   full       fill == DEPTH
module tap_delay_line #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int SEL_WIDTH  = 6,
   parameter int CNT_WIDTH  = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        en,
   input  logic                        din_valid,
   input  logic [DATA_WIDTH-1:0]       din,
   input  logic [SEL_WIDTH-1:0]        sel,
   output logic [DATA_WIDTH*DEPTH-1:0] taps,
   output logic [DEPTH-1:0]            tap_valid,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        dout_valid,
   output logic                        sel_err,
   output logic [CNT_WIDTH-1:0]        fill,
   output logic                        full
);

   // Packed so that the flat tap bus is a plain copy with stage 0 in the low bits.
   logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_q, stage_d;
   logic [DEPTH-1:0]                 valid_q, valid_d;
   logic [CNT_WIDTH-1:0]             fill_q, fill_d;
   logic [DATA_WIDTH-1:0]            dout_q, dout_d;
   logic                             dout_valid_q, dout_valid_d;
   logic                             sel_err_q, sel_err_d;

   always_comb begin
      stage_d      = stage_q;
      valid_d      = valid_q;
      fill_d       = fill_q;
      dout_d       = '0;
      dout_valid_d = 1'b0;
      sel_err_d    = 1'b1;

      // Compare against every legal index instead of indexing with sel, so an
      // out-of-range sel simply matches nothing and falls through to the error value.
      for (int k = 0; k < DEPTH; k++) begin
         if (sel == SEL_WIDTH'(k)) begin
            dout_d       = stage_q[k];
            dout_valid_d = valid_q[k];
            sel_err_d    = 1'b0;
         end
      end

      if (clr) begin
         stage_d      = '0;
         valid_d      = '0;
         fill_d       = '0;
         dout_d       = '0;
         dout_valid_d = 1'b0;
         sel_err_d    = 1'b0;
      end else if (en) begin
         stage_d = {stage_q[DEPTH-2:0], din};
         valid_d = {valid_q[DEPTH-2:0], din_valid};
         // A valid word entering and a valid word leaving cancel out; fill can
         // never pass DEPTH because a full chain always drops a valid word.
         fill_d  = fill_q + CNT_WIDTH'(din_valid) - CNT_WIDTH'(valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q      <= '0;
         valid_q      <= '0;
         fill_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         stage_q      <= stage_d;
         valid_q      <= valid_d;
         fill_q       <= fill_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sel_err_q    <= sel_err_d;
      end
   end

   assign taps       = stage_q;
   assign tap_valid  = valid_q;
   assign fill       = fill_q;
   assign full       = (fill_q == CNT_WIDTH'(DEPTH));
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_tap_delay_line.sv
// Purpose : directed, self-checking bench for tap_delay_line (DEPTH=8 and DEPTH=2 builds).
// Latency : inputs are driven 1 time unit after each rising edge, outputs sampled there too.
// Backpr. : not applicable.
module tb_tap_delay_line;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=8, DATA_WIDTH=32 instance
   logic         clr = 0, en = 0, din_valid = 0;
   logic [31:0]  din = '0;
   logic [5:0]   sel = '0;
   logic [255:0] taps;
   logic [7:0]   tap_valid;
   logic [31:0]  dout;
   logic         dout_valid, sel_err, full;
   logic [6:0]   fill;

   // DEPTH=2, DATA_WIDTH=8 instance
   logic         clr1 = 0, en1 = 0, din_valid1 = 0;
   logic [7:0]   din1 = '0;
   logic [0:0]   sel1 = '0;
   logic [15:0]  taps1;
   logic [1:0]   tap_valid1;
   logic [7:0]   dout1;
   logic         dout_valid1, sel_err1, full1;
   logic [1:0]   fill1;

   int checks = 0;
   int errors = 0;

   tap_delay_line #(.DATA_WIDTH(32), .DEPTH(8), .SEL_WIDTH(6), .CNT_WIDTH(7)) dut (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .din_valid(din_valid), .din(din),
      .sel(sel), .taps(taps), .tap_valid(tap_valid), .dout(dout),
      .dout_valid(dout_valid), .sel_err(sel_err), .fill(fill), .full(full)
   );

   tap_delay_line #(.DATA_WIDTH(8), .DEPTH(2), .SEL_WIDTH(1), .CNT_WIDTH(2)) dut_small (
      .clk(clk), .rst(rst), .clr(clr1), .en(en1), .din_valid(din_valid1), .din(din1),
      .sel(sel1), .taps(taps1), .tap_valid(tap_valid1), .dout(dout1),
      .dout_valid(dout_valid1), .sel_err(sel_err1), .fill(fill1), .full(full1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] tap(input int k);
      return taps[k*32 +: 32];
   endfunction

   // Occupancy invariants, checked on every falling edge for both builds.
   always @(negedge clk) begin
      check("inv_fill8", 64'(fill), 64'($countones(tap_valid)));
      check("inv_full8", 64'(full), 64'(fill == 7'd8));
      check("inv_fill2", 64'(fill1), 64'($countones(tap_valid1)));
      check("inv_full2", 64'(full1), 64'(fill1 == 2'd2));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_v;
      int fill_tab [11];
      logic dv_tab [11];
      fill_tab = '{1, 1, 2, 3, 3, 3, 3, 3, 2, 2, 1};
      dv_tab   = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

      // ---------------- reset state ----------------
      step(); step();
      check("rst_taps_lo", taps[63:0], 64'd0);
      check("rst_taps_hi", taps[255:192], 64'd0);
      check("rst_tap_valid", 64'(tap_valid), 64'd0);
      check("rst_fill", 64'(fill), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_dout_valid", 64'(dout_valid), 64'd0);
      check("rst_sel_err", 64'(sel_err), 64'd0);
      rst = 1'b1;

      // ---------------- reset then fill ----------------
      en = 1; din_valid = 1;
      for (int i = 1; i <= 8; i++) begin
         din = 32'(i);
         step();
         check("fill_count", 64'(fill), 64'(i));
      end
      for (int k = 0; k < 8; k++) check("fill_tap", 64'(tap(k)), 64'(8 - k));
      check("fill_tap_valid", 64'(tap_valid), 64'hFF);
      check("fill_full", 64'(full), 64'd1);
      din = 32'd9;
      step();
      check("full_shift_fill", 64'(fill), 64'd8);
      check("full_shift_tap0", 64'(tap(0)), 64'd9);
      check("full_shift_tap7", 64'(tap(7)), 64'd2);
      // chain now holds stage k = 9-k

      // ---------------- stall ----------------
      en = 0;
      for (int c = 0; c < 5; c++) begin
         din = (c % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
         sel = 6'(c);
         if (c > 0) check("stall_sel_latency", 64'(dout), 64'(9 - (c - 1)));
         step();
         check("stall_dout", 64'(dout), 64'(9 - c));
         check("stall_dout_valid", 64'(dout_valid), 64'd1);
         check("stall_tap0", 64'(tap(0)), 64'd9);
         check("stall_tap7", 64'(tap(7)), 64'd2);
         check("stall_tap_valid", 64'(tap_valid), 64'hFF);
         check("stall_fill", 64'(fill), 64'd8);
      end

      // ---------------- out-of-range select ----------------
      sel = 6'd9;
      step();
      check("sel9_dout", 64'(dout), 64'd0);
      check("sel9_dout_valid", 64'(dout_valid), 64'd0);
      check("sel9_sel_err", 64'(sel_err), 64'd1);
      sel = 6'd7;
      step();
      check("sel7_dout", 64'(dout), 64'd2);
      check("sel7_sel_err", 64'(sel_err), 64'd0);

      // ---------------- flush versus shift ----------------
      clr = 1; en = 1; din = 32'h55; din_valid = 1;
      step();
      clr = 0;
      check("clr_taps_lo", taps[63:0], 64'd0);
      check("clr_taps_hi", taps[255:192], 64'd0);
      check("clr_tap_valid", 64'(tap_valid), 64'd0);
      check("clr_fill", 64'(fill), 64'd0);
      check("clr_dout", 64'(dout), 64'd0);
      check("clr_dout_valid", 64'(dout_valid), 64'd0);
      din = 32'h77;
      step();
      check("post_clr_tap0", 64'(tap(0)), 64'h77);
      check("post_clr_tap1", 64'(tap(1)), 64'd0);
      check("post_clr_tap_valid", 64'(tap_valid), 64'h01);
      check("post_clr_fill", 64'(fill), 64'd1);

      // ---------------- bubbles ----------------
      clr = 1;
      step();
      clr = 0;
      exp_v = '0;
      for (int i = 0; i < 11; i++) begin
         din_valid = dv_tab[i];
         din = 32'h100 + 32'(i);
         exp_v = {exp_v[6:0], dv_tab[i]};
         step();
         check("bubble_fill", 64'(fill), 64'(fill_tab[i]));
         check("bubble_tap_valid", 64'(tap_valid), 64'(exp_v));
      end
      check("bubble_tap0_data", 64'(tap(0)), 64'h10A);

      // ---------------- tap select latency ----------------
      clr = 1; sel = 6'd3;
      step();
      clr = 0; en = 1; din_valid = 1;
      for (int i = 0; i < 6; i++) begin
         din = 32'hA0 + 32'(i);
         step();
         if (i == 3) check("sel3_before_dout_valid", 64'(dout_valid), 64'd0);
         if (i == 4) begin
            check("sel3_dout_A0", 64'(dout), 64'hA0);
            check("sel3_dout_valid", 64'(dout_valid), 64'd1);
         end
         if (i == 5) check("sel3_dout_A1", 64'(dout), 64'hA1);
      end

      // ---------------- async reset mid-stream ----------------
      clr = 1;
      step();
      clr = 0; sel = 6'd9;
      for (int i = 0; i < 4; i++) begin
         din = 32'hC0 + 32'(i);
         step();
      end
      check("half_fill", 64'(fill), 64'd4);
      check("half_sel_err", 64'(sel_err), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_taps_lo", taps[63:0], 64'd0);
      check("arst_tap_valid", 64'(tap_valid), 64'd0);
      check("arst_fill", 64'(fill), 64'd0);
      check("arst_full", 64'(full), 64'd0);
      check("arst_sel_err", 64'(sel_err), 64'd0);
      check("arst_dout", 64'(dout), 64'd0);
      rst = 1'b1;
      sel = 6'd0; din = 32'hBB; din_valid = 1; en = 1;
      step();
      en = 0;
      check("post_arst_tap0", 64'(tap(0)), 64'hBB);
      check("post_arst_tap1", 64'(tap(1)), 64'd0);
      check("post_arst_tap_valid", 64'(tap_valid), 64'h01);
      check("post_arst_fill", 64'(fill), 64'd1);

      // ---------------- DEPTH=2, DATA_WIDTH=8 fill ----------------
      check("small_rst_taps", 64'(taps1), 64'd0);
      check("small_rst_fill", 64'(fill1), 64'd0);
      en1 = 1; din_valid1 = 1; sel1 = 1'b1;
      din1 = 8'd1;
      step();
      check("small_fill1", 64'(fill1), 64'd1);
      check("small_full1", 64'(full1), 64'd0);
      din1 = 8'd2;
      step();
      check("small_taps", 64'(taps1), 64'h0102);
      check("small_tap_valid", 64'(tap_valid1), 64'h3);
      check("small_fill2", 64'(fill1), 64'd2);
      check("small_full2", 64'(full1), 64'd1);
      din1 = 8'd3;
      step();
      check("small_shift_taps", 64'(taps1), 64'h0203);
      check("small_shift_fill", 64'(fill1), 64'd2);
      check("small_dout", 64'(dout1), 64'd1);
      check("small_sel_err", 64'(sel_err1), 64'd0);
      en1 = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
